// File: rtl/ex_bypass_unit_pkg.sv
// Shared definitions for the execute-stage bypass slice: opcode constants
// and the operand-source select encoding.
package ex_bypass_unit_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;

    typedef enum logic [1:0] {
        SEL_RF = 2'd0,
        SEL_XM = 2'd1,
        SEL_MW = 2'd2
    } sel_e;

endpackage

// File: rtl/ex_bypass_unit_select.sv
// Per-source bypass selection: picks regfile, X/M or M/W data for one
// source register and flags a load-use hazard against X/M.
module bypass_select
    import ex_bypass_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic [REG_W-1:0]  src,
    input  logic              src_used,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              xm_valid,
    input  logic              xm_writes,
    input  logic              xm_is_load,
    input  logic [REG_W-1:0]  xm_rd,
    input  logic [DATA_W-1:0] xm_result,
    input  logic              mw_valid,
    input  logic              mw_writes,
    input  logic [REG_W-1:0]  mw_rd,
    input  logic [DATA_W-1:0] mw_data,
    output sel_e              sel,
    output logic [DATA_W-1:0] data,
    output logic              lu_hit
);

    localparam logic [REG_W-1:0] R0 = '0;

    logic xm_src_ne;
    logic xm_rd_nz;
    logic mw_src_ne;
    logic mw_rd_nz;
    logic xm_match;
    logic mw_match;

    not_equal #(.W(REG_W)) u_xm_src (.a(xm_rd), .b(src), .ne(xm_src_ne));
    not_equal #(.W(REG_W)) u_xm_r0  (.a(xm_rd), .b(R0),  .ne(xm_rd_nz));
    not_equal #(.W(REG_W)) u_mw_src (.a(mw_rd), .b(src), .ne(mw_src_ne));
    not_equal #(.W(REG_W)) u_mw_r0  (.a(mw_rd), .b(R0),  .ne(mw_rd_nz));

    // r0 destinations never match, so writes to r0 are invisible here
    assign xm_match = xm_valid & xm_writes & xm_rd_nz & ~xm_src_ne & src_used;
    assign mw_match = mw_valid & mw_writes & mw_rd_nz & ~mw_src_ne;

    always_comb begin
        sel    = SEL_RF;
        data   = rf_data;
        lu_hit = 1'b0;
        if (xm_match && !xm_is_load) begin
            sel  = SEL_XM;
            data = xm_result;
        end else begin
            // a load in X/M has no data yet; the older M/W value is only
            // presented while the controller holds the consumer for one cycle
            lu_hit = xm_match;
            if (mw_match) begin
                sel  = SEL_MW;
                data = mw_data;
            end
        end
    end

endmodule

// File: rtl/not_equal.sv
// Index comparator shared by the bypass logic: ne is high when a and b differ.
module not_equal #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ne
);

    assign ne = |(a ^ b);

endmodule

// File: rtl/ex_bypass_unit.sv
// Execute-stage operand bypass: owns the X/M and M/W destination registers,
// forwards ALU operands and raises a one-cycle load-use stall.
module ex_bypass_unit
    import ex_bypass_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int OP_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [OP_W-1:0]   dx_opcode,
    input  logic [REG_W-1:0]  dx_rs,
    input  logic [REG_W-1:0]  dx_rt,
    input  logic [DATA_W-1:0] dx_data_a,
    input  logic [DATA_W-1:0] dx_data_b,
    input  logic              ex_valid,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] fwd_a,
    output logic [DATA_W-1:0] fwd_b,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic              load_use_stall
);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] result;
    } xm_t;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } mw_t;

    xm_t xm_q;
    mw_t mw_q;

    logic xm_writes;
    logic xm_is_load;
    logic mw_writes;
    logic rs_used;
    logic rt_used;
    logic lu_a;
    logic lu_b;
    sel_e sel_a_e;
    sel_e sel_b_e;

    assign xm_writes  = (xm_q.op == OP_W'(OP_ALU)) || (xm_q.op == OP_W'(OP_ADDI)) ||
                        (xm_q.op == OP_W'(OP_LW));
    assign xm_is_load = (xm_q.op == OP_W'(OP_LW));
    assign mw_writes  = (mw_q.op == OP_W'(OP_ALU)) || (mw_q.op == OP_W'(OP_ADDI)) ||
                        (mw_q.op == OP_W'(OP_LW));

    assign rs_used = (dx_opcode == OP_W'(OP_ALU)) || (dx_opcode == OP_W'(OP_ADDI)) ||
                     (dx_opcode == OP_W'(OP_LW))  || (dx_opcode == OP_W'(OP_SW));
    assign rt_used = (dx_opcode == OP_W'(OP_ALU));

    bypass_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_sel_a (
        .src        (dx_rs),
        .src_used   (rs_used),
        .rf_data    (dx_data_a),
        .xm_valid   (xm_q.valid),
        .xm_writes  (xm_writes),
        .xm_is_load (xm_is_load),
        .xm_rd      (xm_q.rd),
        .xm_result  (xm_q.result),
        .mw_valid   (mw_q.valid),
        .mw_writes  (mw_writes),
        .mw_rd      (mw_q.rd),
        .mw_data    (mw_q.data),
        .sel        (sel_a_e),
        .data       (fwd_a),
        .lu_hit     (lu_a)
    );

    bypass_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_sel_b (
        .src        (dx_rt),
        .src_used   (rt_used),
        .rf_data    (dx_data_b),
        .xm_valid   (xm_q.valid),
        .xm_writes  (xm_writes),
        .xm_is_load (xm_is_load),
        .xm_rd      (xm_q.rd),
        .xm_result  (xm_q.result),
        .mw_valid   (mw_q.valid),
        .mw_writes  (mw_writes),
        .mw_rd      (mw_q.rd),
        .mw_data    (mw_q.data),
        .sel        (sel_b_e),
        .data       (fwd_b),
        .lu_hit     (lu_b)
    );

    assign sel_a          = sel_a_e;
    assign sel_b          = sel_b_e;
    assign load_use_stall = lu_a | lu_b;

    // Global stall holds everything, including a pending flush; the
    // controller re-presents flush once the hold drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            xm_q <= '0;
            mw_q <= '0;
        end else if (!stall) begin
            mw_q.valid <= xm_q.valid;
            mw_q.op    <= xm_q.op;
            mw_q.rd    <= xm_q.rd;
            mw_q.data  <= xm_is_load ? mem_rdata : xm_q.result;
            xm_q.valid <= ex_valid & ~flush & ~load_use_stall;
            xm_q.op    <= dx_opcode;
            xm_q.rd    <= ex_rd;
            xm_q.result <= ex_result;
        end
    end

endmodule

// File: tb/tb_ex_bypass_unit.sv
// Directed bench for ex_bypass_unit: an in-flight-producer model checked every
// cycle, plus literal expectations for the key bypass scenarios.
module tb_ex_bypass_unit;
    import ex_bypass_unit_pkg::*;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [4:0]  dx_opcode;
    logic [4:0]  dx_rs;
    logic [4:0]  dx_rt;
    logic [31:0] dx_data_a;
    logic [31:0] dx_data_b;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic [31:0] mem_rdata;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic        load_use_stall;

    int checks = 0;
    int errors = 0;

    ex_bypass_unit dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .dx_opcode      (dx_opcode),
        .dx_rs          (dx_rs),
        .dx_rt          (dx_rt),
        .dx_data_a      (dx_data_a),
        .dx_data_b      (dx_data_b),
        .ex_valid       (ex_valid),
        .ex_rd          (ex_rd),
        .ex_result      (ex_result),
        .mem_rdata      (mem_rdata),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .sel_a          (sel_a),
        .sel_b          (sel_b),
        .load_use_stall (load_use_stall)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // model: in-flight producers, index 0 = youngest (one stage ahead of X)
    typedef struct {
        logic        v;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [31:0] val;
    } ent_t;

    ent_t pipe [2];

    function automatic logic writes(input logic [4:0] op);
        return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LW);
    endfunction

    function automatic void lookup(input logic [4:0] src, input logic used,
                                   input logic [31:0] rf, output logic [1:0] sel,
                                   output logic [31:0] val, output logic lu);
        logic found;
        sel = 2'd0;
        val = rf;
        lu = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!found && pipe[i].v && writes(pipe[i].op) && pipe[i].rd != 5'd0 &&
                pipe[i].rd == src && (i == 1 || used)) begin
                if (i == 0 && pipe[0].op == OP_LW) begin
                    lu = 1'b1;
                end else begin
                    found = 1'b1;
                    sel = 2'(i + 1);
                    val = pipe[i].val;
                end
            end
        end
    endfunction

    function automatic void expect_all(output logic [1:0] sa, output logic [31:0] fa,
                                       output logic [1:0] sb, output logic [31:0] fb,
                                       output logic lus);
        logic lua;
        logic lub;
        logic rs_used;
        rs_used = (dx_opcode == OP_ALU) || (dx_opcode == OP_ADDI) ||
                  (dx_opcode == OP_LW) || (dx_opcode == OP_SW);
        lookup(dx_rs, rs_used, dx_data_a, sa, fa, lua);
        lookup(dx_rt, dx_opcode == OP_ALU, dx_data_b, sb, fb, lub);
        lus = lua | lub;
    endfunction

    always @(posedge clock) begin
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [31:0] fa;
        logic [31:0] fb;
        logic        lus;
        if (reset) begin
            for (int i = 0; i < 2; i++) pipe[i] = '{1'b0, 5'd0, 5'd0, 32'd0};
        end else if (!stall) begin
            expect_all(sa, fa, sb, fb, lus);
            pipe[1] = pipe[0];
            if (pipe[0].op == OP_LW) pipe[1].val = mem_rdata;
            pipe[0] = '{ex_valid & ~flush & ~lus, dx_opcode, ex_rd, ex_result};
        end
    end

    // compare process: every cycle, mid-period
    always @(negedge clock) begin
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [31:0] fa;
        logic [31:0] fb;
        logic        lus;
        expect_all(sa, fa, sb, fb, lus);
        checks += 5;
        if (sel_a !== sa) begin
            errors++;
            $display("FAIL model_sel_a t=%0t got %0d want %0d", $time, sel_a, sa);
        end
        if (fwd_a !== fa) begin
            errors++;
            $display("FAIL model_fwd_a t=%0t got %h want %h", $time, fwd_a, fa);
        end
        if (sel_b !== sb) begin
            errors++;
            $display("FAIL model_sel_b t=%0t got %0d want %0d", $time, sel_b, sb);
        end
        if (fwd_b !== fb) begin
            errors++;
            $display("FAIL model_fwd_b t=%0t got %h want %h", $time, fwd_b, fb);
        end
        if (load_use_stall !== lus) begin
            errors++;
            $display("FAIL model_lus t=%0t got %0b want %0b", $time, load_use_stall, lus);
        end
    end

    // driver: present one X-stage instruction just after the clock edge
    task automatic present(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [31:0] da, input logic [31:0] db, input logic v,
                           input logic [4:0] rd, input logic [31:0] res,
                           input logic [31:0] mr, input logic fl, input logic st);
        @(posedge clock);
        #1;
        dx_opcode = op;
        dx_rs     = rs;
        dx_rt     = rt;
        dx_data_a = da;
        dx_data_b = db;
        ex_valid  = v;
        ex_rd     = rd;
        ex_result = res;
        mem_rdata = mr;
        flush     = fl;
        stall     = st;
    endtask

    task automatic check_lit(input string name, input logic [1:0] sa, input logic [31:0] fa,
                             input logic [1:0] sb, input logic [31:0] fb, input logic lus);
        @(negedge clock);
        #1;
        checks++;
        if (sel_a !== sa || fwd_a !== fa || sel_b !== sb || fwd_b !== fb ||
            load_use_stall !== lus) begin
            errors++;
            $display("FAIL %s got sel_a=%0d fwd_a=%h sel_b=%0d fwd_b=%h lus=%0b want sel_a=%0d fwd_a=%h sel_b=%0d fwd_b=%h lus=%0b",
                     name, sel_a, fwd_a, sel_b, fwd_b, load_use_stall, sa, fa, sb, fb, lus);
        end
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        dx_opcode = OP_ALU;
        dx_rs = 5'd1;
        dx_rt = 5'd2;
        dx_data_a = 32'h0;
        dx_data_b = 32'h0;
        ex_valid = 1'b0;
        ex_rd = 5'd0;
        ex_result = 32'h0;
        mem_rdata = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        dx_data_a = 32'h11;
        dx_data_b = 32'h22;
        check_lit("reset_state", 2'd0, 32'h11, 2'd0, 32'h22, 1'b0);

        // X/M then M/W forwarding of an ADDI result
        present(OP_ADDI, 5'd1, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h5, 32'h0, 1'b0, 1'b0);
        present(OP_ALU, 5'd3, 5'd6, 32'hdead, 32'hbeef, 1'b1, 5'd8, 32'h77, 32'h0, 1'b0, 1'b0);
        check_lit("fwd_xm", 2'd1, 32'h5, 2'd0, 32'hbeef, 1'b0);
        present(OP_ALU, 5'd3, 5'd8, 32'haaaa, 32'hbbbb, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_lit("fwd_mw", 2'd2, 32'h5, 2'd1, 32'h77, 1'b0);

        // X/M wins over M/W for the same register
        present(OP_ADDI, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4, 32'hB, 32'h0, 1'b0, 1'b0);
        present(OP_ADDI, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4, 32'hA, 32'h0, 1'b0, 1'b0);
        present(OP_ALU, 5'd4, 5'd4, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_lit("xm_priority", 2'd1, 32'hA, 2'd1, 32'hA, 1'b0);

        // load-use: one stall cycle, bubble in X/M, then M/W forwards load data
        present(OP_LW, 5'd1, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 32'h100, 32'h0, 1'b0, 1'b0);
        present(OP_ALU, 5'd1, 5'd7, 32'h31, 32'h32, 1'b1, 5'd7, 32'h55, 32'h99, 1'b0, 1'b0);
        check_lit("load_use_stall", 2'd0, 32'h31, 2'd0, 32'h32, 1'b1);
        present(OP_ALU, 5'd1, 5'd7, 32'h31, 32'h32, 1'b1, 5'd7, 32'h55, 32'h12, 1'b0, 1'b0);
        check_lit("load_fwd_mw", 2'd0, 32'h31, 2'd2, 32'h99, 1'b0);

        // r0 is never forwarded
        present(OP_ALU, 5'd1, 5'd1, 32'h0, 32'h0, 1'b1, 5'd0, 32'h3, 32'h0, 1'b0, 1'b0);
        present(OP_ALU, 5'd0, 5'd0, 32'h21, 32'h22, 1'b1, 5'd0, 32'h4, 32'h0, 1'b0, 1'b0);
        check_lit("r0_xm", 2'd0, 32'h21, 2'd0, 32'h22, 1'b0);
        present(OP_ALU, 5'd0, 5'd0, 32'h23, 32'h24, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_lit("r0_mw", 2'd0, 32'h23, 2'd0, 32'h24, 1'b0);

        // flush squashes the instruction entering X/M
        present(OP_ADDI, 5'd1, 5'd0, 32'h0, 32'h0, 1'b1, 5'd2, 32'h42, 32'h0, 1'b1, 1'b0);
        present(OP_ALU, 5'd2, 5'd2, 32'h13, 32'h14, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_lit("flush_xm", 2'd0, 32'h13, 2'd0, 32'h14, 1'b0);
        present(OP_ALU, 5'd2, 5'd2, 32'h13, 32'h14, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_lit("flush_mw", 2'd0, 32'h13, 2'd0, 32'h14, 1'b0);

        // SW reads rs but not rt
        present(OP_ADDI, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 32'h90, 32'h0, 1'b0, 1'b0);
        present(OP_SW, 5'd9, 5'd9, 32'h1, 32'h2, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_lit("sw_rt_unused", 2'd1, 32'h90, 2'd0, 32'h2, 1'b0);

        // global stall freezes both pipe registers for three cycles
        present(OP_ADDI, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6, 32'h60, 32'h0, 1'b0, 1'b0);
        present(OP_ADDI, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h50, 32'h0, 1'b0, 1'b0);
        present(OP_ALU, 5'd5, 5'd6, 32'h1, 32'h2, 1'b1, 5'd11, 32'hff, 32'h0, 1'b0, 1'b1);
        check_lit("stall_0", 2'd1, 32'h50, 2'd2, 32'h60, 1'b0);
        present(OP_ALU, 5'd5, 5'd6, 32'h1, 32'h2, 1'b1, 5'd5, 32'hee, 32'h77, 1'b1, 1'b1);
        check_lit("stall_1", 2'd1, 32'h50, 2'd2, 32'h60, 1'b0);
        present(OP_ALU, 5'd5, 5'd6, 32'h1, 32'h2, 1'b1, 5'd6, 32'hdd, 32'h66, 1'b0, 1'b1);
        check_lit("stall_2", 2'd1, 32'h50, 2'd2, 32'h60, 1'b0);
        present(OP_ALU, 5'd5, 5'd6, 32'h1, 32'h2, 1'b1, 5'd11, 32'hff, 32'h0, 1'b0, 1'b0);
        check_lit("stall_release", 2'd1, 32'h50, 2'd2, 32'h60, 1'b0);
        present(OP_ALU, 5'd5, 5'd11, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_lit("after_stall", 2'd2, 32'h50, 2'd1, 32'hff, 1'b0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
